// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit_if
//  Brief    : ALU <-> multiply/divide unit bundle. It carries the operands,
//             the request/control bits, the HI/LO results and the
//             stall/done status.
//  Revision : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        mult;
    logic        md;
    logic        signed_calc;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
    logic        done;

    // ALU / pipeline side
    modport master (
        output md_a, md_b, mult, md, signed_calc, flush,
        input  hi, lo, stall, done
    );

    // Multiply/divide unit side
    modport slave (
        input  md_a, md_b, mult, md, signed_calc, flush,
        output hi, lo, stall, done
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Brief    : Multi-cycle multiply/divide unit with HI/LO result registers.
//             Multiply uses iterative shift-add. Divide uses iterative
//             restoring division with signed fix-up. While an operation is
//             in flight, the unit raises stall.
//             Optional macro MULDIV_FAST_MULT_EN: single-cycle 32x32 multiply.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int DIV_ITER = 32
) (
    input  logic         clk,
    input  logic         rst,      // asynchronous, active low
    muldiv_unit_if.slave bus
);
    localparam int c_CNT_W = $clog2(DIV_ITER);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIV_ITER - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             r_state, w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [63:0]        r_acc;     // product, or {remainder, quotient}
    logic [31:0]        r_b;       // magnitude of the multiplier or divisor
    logic               r_mult;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [31:0]        r_hi, r_lo;
    logic               w_stall, w_done;

`ifdef MULDIV_FAST_MULT_EN
    localparam bit c_FAST_MULT = 1'b1;
    logic [63:0] w_ax, w_bx, w_fast_prod;
    // Sign-extend when signed. The low 64 bits of the product are then
    // correct for both signed and unsigned operands.
    assign w_ax        = {{32{bus.signed_calc & bus.md_a[31]}}, bus.md_a};
    assign w_bx        = {{32{bus.signed_calc & bus.md_b[31]}}, bus.md_b};
    assign w_fast_prod = w_ax * w_bx;
`else
    localparam bit c_FAST_MULT = 1'b0;
    logic [63:0] w_fast_prod;
    assign w_fast_prod = 64'd0;
`endif

    logic        w_start, w_div_zero;
    logic [31:0] w_a_mag, w_b_mag;
    assign w_start    = (r_state == IDLE) && bus.md && !bus.flush;
    assign w_div_zero = (bus.md_b == 32'd0);
    assign w_a_mag    = (bus.signed_calc && bus.md_a[31]) ? (~bus.md_a + 32'd1) : bus.md_a;
    assign w_b_mag    = (bus.signed_calc && bus.md_b[31]) ? (~bus.md_b + 32'd1) : bus.md_b;

    // Shift-add step: conditionally add into the upper half, then shift right.
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Restoring step: shift the next dividend bit into the remainder, then
    // subtract the divisor if it fits.
    logic [32:0] w_div_sh, w_div_sub;
    logic        w_div_ge;
    logic [63:0] w_div_next;
    assign w_div_sh   = r_acc[63:31];
    assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
    assign w_div_sub  = w_div_sh - {1'b0, r_b};
    assign w_div_next = w_div_ge ? {w_div_sub[31:0], r_acc[30:0], 1'b1}
                                 : {w_div_sh[31:0],  r_acc[30:0], 1'b0};

    // Sign fix-up. The neg flags are cleared for unsigned operations.
    logic [63:0] w_prod_fix;
    logic [31:0] w_fix_hi, w_fix_lo;
    assign w_prod_fix = r_neg_q ? (~r_acc + 64'd1) : r_acc;
    assign w_fix_lo   = r_mult ? w_prod_fix[31:0]  : (r_neg_q ? (~r_acc[31:0]  + 32'd1) : r_acc[31:0]);
    assign w_fix_hi   = r_mult ? w_prod_fix[63:32] : (r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32]);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic and status outputs. A flush wins over everything else.
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = bus.md && !bus.flush;
                if (w_start) begin
                    if (bus.mult)        w_next = c_FAST_MULT ? DONE : MUL;
                    else if (w_div_zero) w_next = DONE;
                    else                 w_next = DIV;
                end
            end
            MUL, DIV: begin
                w_stall = 1'b1;
                if (r_cnt == c_LAST) w_next = FIX;
            end
            FIX: begin
                w_stall = 1'b1;
                w_next  = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (bus.flush) w_next = IDLE;
    end

    // Datapath: operand latch, iteration, and HI/LO commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_mult  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (bus.flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.md) begin
                        r_cnt   <= '0;
                        r_mult  <= bus.mult;
                        r_acc   <= {32'd0, w_a_mag};
                        r_b     <= w_b_mag;
                        r_neg_q <= bus.signed_calc & (bus.md_a[31] ^ bus.md_b[31]);
                        r_neg_r <= bus.signed_calc & bus.md_a[31];
                        if (bus.mult && c_FAST_MULT) begin
                            r_hi <= w_fast_prod[63:32];
                            r_lo <= w_fast_prod[31:0];
                        end else if (!bus.mult && w_div_zero) begin
                            r_hi <= bus.md_a;
                            r_lo <= 32'hFFFF_FFFF;
                        end
                    end
                end
                MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.stall = w_stall;
    assign bus.done  = w_done;
endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit in the execute stage, directly downstream of the ALU. It consumes the ALU's `md_a`, `md_b`, `mult`, `md` and `signed_calc` outputs and computes a 64-bit product or a quotient/remainder pair into the HI/LO registers. It raises `stall` to freeze the pipeline until the result is committed.

## Interface
- `DIV_ITER`, 32: restoring-divide iterations. Fixed at 32 for 32-bit operands.
- `clk  in  1`: the only clock. All state changes on the rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `md_a  in  32`: operand A, the multiplicand or dividend.
- `md_b  in  32`: operand B, the multiplier or divisor.
- `mult  in  1`: 1 selects multiply, 0 selects divide. Sampled only at start.
- `md  in  1`: request. Held high by the ALU for the whole instruction.
- `signed_calc  in  1`: 1 selects signed (mult/div), 0 selects unsigned (multu/divu).
- `flush  in  1`: aborts any operation in progress.
- `hi  out  32`: HI register. Receives the upper product half or the remainder.
- `lo  out  32`: LO register. Receives the lower product half or the quotient.
- `stall  out  1`: pipeline hold request.
- `done  out  1`: one-cycle pulse when HI/LO are written.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - If `md`=1 and `flush`=0, latch the operands, `mult` and `signed_calc`.
  - When signed, convert both operands to magnitudes and record `neg_q = a[31]^b[31]` and `neg_r = a[31]`.
  - Next state: MUL, or DIV, or DONE for a zero divisor.
- MUL: shift-add multiply, 32 iterations on the magnitudes, accumulating into a 64-bit register. Then go to FIX.
- DIV: restoring divide, 32 iterations. Each iteration shifts the remainder left by one bit and subtracts the divisor with a 33-bit compare. Then go to FIX.
- FIX, signed only:
  - Negate the product if `neg_q`.
  - Negate the quotient if `neg_q` and the remainder if `neg_r`.
  - Unsigned operations pass through unchanged.
- DONE:
  - `hi` and `lo` are written on entry to DONE and are valid there.
  - `done`=1 for exactly one cycle.
  - `md` is ignored in DONE, because it is still the same instruction.
  - Next state: IDLE.
- Divide by zero, signed or unsigned: go IDLE to DONE directly. Result is `lo`=0xFFFFFFFF and `hi`=`md_a` unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000 and `hi`=0. No trap.
- `flush`=1 in any state: go to IDLE next cycle. `hi`/`lo` are not written and `done` is not pulsed. `flush` has priority over a start in the same cycle.
- Reset (`rst`=0), at any time including mid-operation:
  - State goes to IDLE and the iteration counter clears.
  - `hi`=0, `lo`=0, `done`=0.
- `hi`/`lo` hold their values between operations.

## Timing
- `stall` is combinational: `stall = (state==IDLE & md & ~flush) | state∈{MUL,DIV,FIX}`. It is 0 in DONE and after reset.
- Let T be the IDLE cycle in which `md` is sampled high. Results appear as follows:
  - Iterative multiply and any divide: MUL or DIV occupies T+1..T+32, FIX is T+33, and DONE is T+34 with the result valid.
  - Divide by zero: DONE at T+1.
  - Multiply with `MULDIV_FAST_MULT_EN`: DONE at T+1.
- The pipeline advances in the DONE cycle. A new `md` request is accepted no earlier than the following IDLE cycle, T+35 in the iterative case.
- The operand latch makes changes on `md_a`/`md_b` after T irrelevant to the result.

## Configuration
- `MULDIV_FAST_MULT_EN` defined:
  - Multiply is one signed/unsigned 32x32 multiply.
  - Go IDLE to DONE, registering `{hi,lo}` at the T+1 edge. MUL and FIX are unused for multiply.
- Not defined:
  - Iterative shift-add as above, 34-cycle latency, no hardware multiplier inferred.
- Division is iterative in both builds.

## Test plan
- mult, a=0xFFFFFFFE, b=0x00000003 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
  - `done` at T+34, or T+1 with the macro.
  - `stall` is high from T until `done`.
- multu, a=0xFFFFFFFE, b=0x00000003 → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- div, a=0xFFFFFFF9 (-7), b=0x00000002 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, `done` at T+34.
- divu, a=0x00000064, b=0 → `lo`=0xFFFFFFFF, `hi`=0x00000064, `done` at T+1.
- div, a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0x00000000.
- Abort and reset mid-operation:
  - Preset `hi`/`lo` with a prior op, then start divu 100/7 and assert `flush` at T+10. Expect `stall`=0 from T+11, no `done`, `hi`/`lo` unchanged.
  - Repeat with `rst`=0 at T+10. Expect `hi`=`lo`=0 immediately, then a fresh divu 100/7 giving `lo`=14, `hi`=2.
